alu_issue: RTL

Issue/sequencing stage directly upstream of the ALU in the CPU core. Accepts one decoded RV32IM register/immediate/branch instruction per handshake, maps it to an `ALUOP_*` code from `cpu/aludefs.vh`, and selects the operands. It pulses the ALU enable, holds operands stable while the ALU reports busy (shifts, divides), then presents either a register-writeback or a branch-resolution result to the next stage.

---
 rtl/alu_issue.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: issue/sequencing stage in front of the ALU.
//
// Accepts one decoded RV32IM OP / OP-IMM / LUI / AUIPC / BRANCH instruction
// per handshake. It maps the instruction to an ALU opcode, selects the
// operands, pulses the ALU enable, and holds the operands while the ALU is
// busy. It then presents a writeback or branch-resolution bundle downstream.
//
// Ports
//   I_clk, I_reset      clock; synchronous active-high reset (shared with ALU)
//   I_valid / O_ready   upstream handshake, decoded instruction fields:
//     I_opcode, I_funct3, I_funct7, I_rd, I_pc, I_rs1, I_rs2, I_imm
//   O_alu_en            one-cycle ALU start pulse
//   O_alu_op/s1/s2      ALU opcode and operands, stable from EXEC to DONE
//   I_alu_busy/data     ALU busy flag and result
//   I_alu_lt/ltu/eq     ALU comparison flags
//   O_valid / I_ready   downstream handshake for the result bundle:
//     O_wb_en, O_rd, O_data, O_br, O_br_taken, O_br_target
//
// FSM: IDLE -> EXEC -> WAIT (until busy low) -> DONE (until I_ready) -> IDLE.

module alu_issue (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [6:0]  I_opcode,
  input  logic [2:0]  I_funct3,
  input  logic [6:0]  I_funct7,
  input  logic [4:0]  I_rd,
  input  logic [31:0] I_pc,
  input  logic [31:0] I_rs1,
  input  logic [31:0] I_rs2,
  input  logic [31:0] I_imm,
  output logic        O_alu_en,
  output logic [4:0]  O_alu_op,
  output logic [31:0] O_alu_s1,
  output logic [31:0] O_alu_s2,
  input  logic        I_alu_busy,
  input  logic [31:0] I_alu_data,
  input  logic        I_alu_lt,
  input  logic        I_alu_ltu,
  input  logic        I_alu_eq,
  output logic        O_valid,
  input  logic        I_ready,
  output logic        O_wb_en,
  output logic [4:0]  O_rd,
  output logic [31:0] O_data,
  output logic        O_br,
  output logic        O_br_taken,
  output logic [31:0] O_br_target
);

  // ALU opcode encoding shared with the ALU (cpu/aludefs.vh values).
  localparam logic [4:0] ALUOP_ADD    = 5'd0;
  localparam logic [4:0] ALUOP_SUB    = 5'd1;
  localparam logic [4:0] ALUOP_SLL    = 5'd2;
  localparam logic [4:0] ALUOP_SLT    = 5'd3;
  localparam logic [4:0] ALUOP_SLTU   = 5'd4;
  localparam logic [4:0] ALUOP_XOR    = 5'd5;
  localparam logic [4:0] ALUOP_SRL    = 5'd6;
  localparam logic [4:0] ALUOP_SRA    = 5'd7;
  localparam logic [4:0] ALUOP_OR     = 5'd8;
  localparam logic [4:0] ALUOP_AND    = 5'd9;
  localparam logic [4:0] ALUOP_MUL    = 5'd10;
  localparam logic [4:0] ALUOP_MULH   = 5'd11;
  localparam logic [4:0] ALUOP_MULHSU = 5'd12;
  localparam logic [4:0] ALUOP_MULHU  = 5'd13;
  localparam logic [4:0] ALUOP_DIV    = 5'd14;
  localparam logic [4:0] ALUOP_DIVU   = 5'd15;
  localparam logic [4:0] ALUOP_REM    = 5'd16;
  localparam logic [4:0] ALUOP_REMU   = 5'd17;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_d;

  // Base integer funct3 mapping. Only the register form may select SUB;
  // both forms use the alt bit (funct7[5]) to pick SRA over SRL.
  function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    logic [4:0] op;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALUOP_SUB : ALUOP_ADD;
      3'b001:  op = ALUOP_SLL;
      3'b010:  op = ALUOP_SLT;
      3'b011:  op = ALUOP_SLTU;
      3'b100:  op = ALUOP_XOR;
      3'b101:  op = alt ? ALUOP_SRA : ALUOP_SRL;
      3'b110:  op = ALUOP_OR;
      default: op = ALUOP_AND;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] muldiv_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALUOP_MUL;
      3'b001:  op = ALUOP_MULH;
      3'b010:  op = ALUOP_MULHSU;
      3'b011:  op = ALUOP_MULHU;
      3'b100:  op = ALUOP_DIV;
      3'b101:  op = ALUOP_DIVU;
      3'b110:  op = ALUOP_REM;
      default: op = ALUOP_REMU;
    endcase
    return op;
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic lt,
                                       input logic ltu, input logic eq);
    logic c;
    case (f3)
      3'b000:  c = eq;
      3'b001:  c = !eq;
      3'b100:  c = lt;
      3'b101:  c = !lt;
      3'b110:  c = ltu;
      3'b111:  c = !ltu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Decode of the incoming instruction; only used on the accept cycle.
  logic [4:0]  dec_op;
  logic [31:0] dec_s1, dec_s2, dec_target;
  logic        dec_wb, dec_br;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_op     = ALUOP_ADD;
    dec_s1     = I_rs1;
    dec_s2     = I_imm;
    dec_wb     = 1'b0;
    dec_br     = 1'b0;
    dec_target = '0;
    case (I_opcode)
      OPC_OP: begin
        dec_op = (I_funct7 == F7_MULDIV) ? muldiv_op(I_funct3)
                                         : base_op(I_funct3, I_funct7[5], 1'b1);
        dec_s2 = I_rs2;
        dec_wb = (I_rd != 5'd0);
      end
      OPC_OP_IMM: begin
        dec_op = base_op(I_funct3, I_funct7[5], 1'b0);
        dec_wb = (I_rd != 5'd0);
      end
      OPC_LUI: begin
        dec_s1 = '0;
        dec_wb = (I_rd != 5'd0);
      end
      OPC_AUIPC: begin
        dec_s1 = I_pc;
        dec_wb = (I_rd != 5'd0);
      end
      OPC_BRANCH: begin
        dec_op     = ALUOP_SUB;
        dec_s2     = I_rs2;
        dec_br     = 1'b1;
        dec_target = I_pc + I_imm;  // 32-bit wrap-around
      end
      default: ;  // unsupported opcode: completes as an ADD bubble
    endcase
  end

  logic accept;
  assign O_ready = (state == S_IDLE) && !I_reset;
  assign accept  = I_valid && O_ready;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: state_d = S_WAIT;
      S_WAIT: if (!I_alu_busy) state_d = S_DONE;
      S_DONE: if (I_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge I_clk) begin
    if (I_reset) state <= S_IDLE;
    else         state <= state_d;
  end

  logic [4:0]  op_q, rd_q;
  logic [31:0] s1_q, s2_q, data_q, target_q;
  logic [2:0]  f3_q;
  logic        wb_q, br_q, taken_q;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      op_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      rd_q     <= '0;
      f3_q     <= '0;
      wb_q     <= 1'b0;
      br_q     <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q     <= dec_op;
          s1_q     <= dec_s1;
          s2_q     <= dec_s2;
          rd_q     <= I_rd;
          f3_q     <= I_funct3;
          wb_q     <= dec_wb;
          br_q     <= dec_br;
          target_q <= dec_target;
          taken_q  <= 1'b0;
        end
        S_WAIT: if (!I_alu_busy) begin
          data_q  <= I_alu_data;
          taken_q <= br_q && branch_cond(f3_q, I_alu_lt, I_alu_ltu, I_alu_eq);
        end
        default: ;
      endcase
    end
  end

  assign O_alu_en    = (state == S_EXEC);
  assign O_alu_op    = op_q;
  assign O_alu_s1    = s1_q;
  assign O_alu_s2    = s2_q;
  assign O_valid     = (state == S_DONE);
  assign O_wb_en     = wb_q;
  assign O_rd        = rd_q;
  assign O_data      = data_q;
  assign O_br        = br_q;
  assign O_br_taken  = taken_q;
  assign O_br_target = target_q;

endmodule
